// File: rtl/pc_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// pc_redirect_ctrl
//
// Central sequencer for the PC register. It arbitrates the redirect sources
// (CLINT interrupt, EX branch/jump, JTAG reset/halt) and the stall sources
// (EX, bus) into one registered jump_flag/jump_addr pair, a hold level and a
// JTAG reset pulse train. After every redirect a short flush window holds ID
// so wrong-path fetches drain before the pipe resumes.
//
// Optional feature macro: PC_CTRL_STATS_EN
//   defined   -> adds jump_cnt_o / hold_cnt_o saturating statistics counters
//   undefined -> those ports and counters are absent
//
// Ports
//   clk                in   1   clock, all state on posedge
//   rst                in   1   synchronous reset, active-high
//   ex_jump_req_i      in   1   EX branch/jump taken
//   ex_jump_addr_i     in   32  EX target
//   ex_hold_req_i      in   1   EX multi-cycle op stall
//   rib_hold_req_i     in   1   bus busy stall
//   clint_int_req_i    in   1   interrupt request (level, held until int_ack_o)
//   clint_int_addr_i   in   32  trap vector
//   jtag_halt_req_i    in   1   debug halt (level)
//   jtag_reset_req_i   in   1   debug core reset request
//   jump_flag_o        out  1   registered redirect pulse to pc_reg
//   jump_addr_o        out  32  registered redirect target (holds last target)
//   hold_flag_o        out  3   0 none, 1 hold PC, 2 hold IF, 3 hold ID
//   jtag_reset_flag_o  out  1   registered core reset to pc_reg/pipe
//   int_ack_o          out  1   registered, pulses with interrupt redirect
//   halted_o           out  1   1 while halted by debugger
//   jump_cnt_o         out  CNT_W  jump_flag_o pulse count (stats build only)
//   hold_cnt_o         out  CNT_W  cycles with hold_flag_o != 0 (stats build only)
// -----------------------------------------------------------------------------
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
    parameter int          JTAG_RST_CYCLES = 4,
    parameter int          FLUSH_CYCLES    = 1,
    parameter int          CNT_W           = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_jump_req_i,
    input  logic [31:0]       ex_jump_addr_i,
    input  logic              ex_hold_req_i,
    input  logic              rib_hold_req_i,
    input  logic              clint_int_req_i,
    input  logic [31:0]       clint_int_addr_i,
    input  logic              jtag_halt_req_i,
    input  logic              jtag_reset_req_i,
    output logic              jump_flag_o,
    output logic [31:0]       jump_addr_o,
    output logic [2:0]        hold_flag_o,
    output logic              jtag_reset_flag_o,
    output logic              int_ack_o,
    output logic              halted_o
`ifdef PC_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0]  jump_cnt_o,
    output logic [CNT_W-1:0]  hold_cnt_o
`endif
);

    localparam int RW = $clog2(JTAG_RST_CYCLES + 1);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    localparam logic [2:0] HOLD_NONE = 3'd0;
    localparam logic [2:0] HOLD_PC   = 3'd1;
    localparam logic [2:0] HOLD_ID   = 3'd3;

    // Zero-length pulse trains or windows make no sense; stop elaboration.
    if (JTAG_RST_CYCLES < 1) begin : g_bad_jrst
        $error("pc_redirect_ctrl: JTAG_RST_CYCLES must be >= 1");
    end
    if (FLUSH_CYCLES < 1) begin : g_bad_flush
        $error("pc_redirect_ctrl: FLUSH_CYCLES must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("pc_redirect_ctrl: CNT_W must be >= 1");
    end

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2,
        JRST  = 2'd3
    } state_t;

    state_t        state;
    logic [FW-1:0] flush_cnt;
    logic [RW-1:0] rst_cnt;

    // Any request that RUN would act on this cycle; stalls only apply when
    // nothing of higher priority is being taken.
    logic redirect_pending;
    assign redirect_pending = jtag_reset_req_i | clint_int_req_i |
                              ex_jump_req_i | jtag_halt_req_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= RUN;
            jump_flag_o       <= 1'b0;
            jump_addr_o       <= RESET_ADDR;
            jtag_reset_flag_o <= 1'b0;
            int_ack_o         <= 1'b0;
            halted_o          <= 1'b0;
            flush_cnt         <= '0;
            rst_cnt           <= '0;
        end else begin
            // Redirect and ack are single-cycle pulses.
            jump_flag_o <= 1'b0;
            int_ack_o   <= 1'b0;
            case (state)
                RUN: begin
                    if (jtag_reset_req_i) begin
                        state             <= JRST;
                        rst_cnt           <= RW'(JTAG_RST_CYCLES);
                        jtag_reset_flag_o <= 1'b1;
                    end else if (clint_int_req_i) begin
                        jump_flag_o <= 1'b1;
                        jump_addr_o <= clint_int_addr_i;
                        int_ack_o   <= 1'b1;
                        flush_cnt   <= FW'(FLUSH_CYCLES);
                        state       <= FLUSH;
                    end else if (ex_jump_req_i) begin
                        jump_flag_o <= 1'b1;
                        jump_addr_o <= ex_jump_addr_i;
                        flush_cnt   <= FW'(FLUSH_CYCLES);
                        state       <= FLUSH;
                    end else if (jtag_halt_req_i) begin
                        halted_o <= 1'b1;
                        state    <= HALT;
                    end
                end
                FLUSH: begin
                    // EX requests here come from the wrong path and are dropped;
                    // level interrupts/halts are picked up again once in RUN.
                    if (jtag_reset_req_i) begin
                        state             <= JRST;
                        rst_cnt           <= RW'(JTAG_RST_CYCLES);
                        jtag_reset_flag_o <= 1'b1;
                        flush_cnt         <= '0;
                    end else if (flush_cnt <= FW'(1)) begin
                        flush_cnt <= '0;
                        state     <= RUN;
                    end else begin
                        flush_cnt <= flush_cnt - FW'(1);
                    end
                end
                HALT: begin
                    if (jtag_reset_req_i) begin
                        halted_o          <= 1'b0;
                        state             <= JRST;
                        rst_cnt           <= RW'(JTAG_RST_CYCLES);
                        jtag_reset_flag_o <= 1'b1;
                    end else if (!jtag_halt_req_i) begin
                        halted_o <= 1'b0;
                        state    <= RUN;
                    end
                end
                JRST: begin
                    // Fixed-length train: a new request here does not reload.
                    if (rst_cnt <= RW'(1)) begin
                        rst_cnt           <= '0;
                        jtag_reset_flag_o <= 1'b0;
                        state             <= RUN;
                    end else begin
                        rst_cnt <= rst_cnt - RW'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Hold level: derived from the registered state outside RUN, from the
    // stall inputs inside RUN. EX stall dominates the bus stall.
    always_comb begin
        hold_flag_o = HOLD_NONE;
        if (state == RUN) begin
            if (!redirect_pending) begin
                if (ex_hold_req_i) begin
                    hold_flag_o = HOLD_ID;
                end else if (rib_hold_req_i) begin
                    hold_flag_o = HOLD_PC;
                end
            end
        end else begin
            hold_flag_o = HOLD_ID;
        end
    end

`ifdef PC_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            jump_cnt_o <= '0;
            hold_cnt_o <= '0;
        end else begin
            if (jump_flag_o && (jump_cnt_o != {CNT_W{1'b1}})) begin
                jump_cnt_o <= jump_cnt_o + CNT_W'(1);
            end
            if ((hold_flag_o != HOLD_NONE) && (hold_cnt_o != {CNT_W{1'b1}})) begin
                hold_cnt_o <= hold_cnt_o + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_redirect_ctrl
//
// Directed bench for pc_redirect_ctrl with default parameters
// (RESET_ADDR=0, JTAG_RST_CYCLES=4, FLUSH_CYCLES=1). Expected values are
// hand-computed constants. Stats counters are checked when PC_CTRL_STATS_EN
// is defined.
// -----------------------------------------------------------------------------
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_jump_req_i;
    logic [31:0] ex_jump_addr_i;
    logic        ex_hold_req_i;
    logic        rib_hold_req_i;
    logic        clint_int_req_i;
    logic [31:0] clint_int_addr_i;
    logic        jtag_halt_req_i;
    logic        jtag_reset_req_i;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic [2:0]  hold_flag_o;
    logic        jtag_reset_flag_o;
    logic        int_ack_o;
    logic        halted_o;
`ifdef PC_CTRL_STATS_EN
    logic [31:0] jump_cnt_o;
    logic [31:0] hold_cnt_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    pc_redirect_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .ex_jump_req_i     (ex_jump_req_i),
        .ex_jump_addr_i    (ex_jump_addr_i),
        .ex_hold_req_i     (ex_hold_req_i),
        .rib_hold_req_i    (rib_hold_req_i),
        .clint_int_req_i   (clint_int_req_i),
        .clint_int_addr_i  (clint_int_addr_i),
        .jtag_halt_req_i   (jtag_halt_req_i),
        .jtag_reset_req_i  (jtag_reset_req_i),
        .jump_flag_o       (jump_flag_o),
        .jump_addr_o       (jump_addr_o),
        .hold_flag_o       (hold_flag_o),
        .jtag_reset_flag_o (jtag_reset_flag_o),
        .int_ack_o         (int_ack_o),
        .halted_o          (halted_o)
`ifdef PC_CTRL_STATS_EN
        ,
        .jump_cnt_o        (jump_cnt_o),
        .hold_cnt_o        (hold_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        ex_jump_req_i    = 1'b0;
        ex_jump_addr_i   = 32'h0;
        ex_hold_req_i    = 1'b0;
        rib_hold_req_i   = 1'b0;
        clint_int_req_i  = 1'b0;
        clint_int_addr_i = 32'h0;
        jtag_halt_req_i  = 1'b0;
        jtag_reset_req_i = 1'b0;

        // 1: reset values
        tick();
        check("rst_jump_flag", 32'(jump_flag_o), 32'd0);
        check("rst_jump_addr", jump_addr_o, 32'h0);
        check("rst_hold", 32'(hold_flag_o), 32'd0);
        check("rst_jtag_flag", 32'(jtag_reset_flag_o), 32'd0);
        check("rst_int_ack", 32'(int_ack_o), 32'd0);
        check("rst_halted", 32'(halted_o), 32'd0);
`ifdef PC_CTRL_STATS_EN
        check("rst_jump_cnt", jump_cnt_o, 32'd0);
        check("rst_hold_cnt", hold_cnt_o, 32'd0);
`endif
        rst = 1'b0;

        // 2: EX jump, then wrong-path jump during flush is dropped
        ex_jump_req_i  = 1'b1;
        ex_jump_addr_i = 32'h100;
        tick();
        check("ex_jump_flag", 32'(jump_flag_o), 32'd1);
        check("ex_jump_addr", jump_addr_o, 32'h100);
        check("ex_flush_hold", 32'(hold_flag_o), 32'd3);
        ex_jump_addr_i = 32'h200;
        tick();
        check("flush_drop_flag", 32'(jump_flag_o), 32'd0);
        check("flush_drop_addr", jump_addr_o, 32'h100);
        ex_jump_req_i = 1'b0;
        #1;
        check("post_flush_hold", 32'(hold_flag_o), 32'd0);
        tick();
        check("post_flush_flag", 32'(jump_flag_o), 32'd0);
        check("post_flush_addr", jump_addr_o, 32'h100);

        // 3: interrupt beats EX jump in the same cycle
        clint_int_req_i  = 1'b1;
        clint_int_addr_i = 32'h80;
        ex_jump_req_i    = 1'b1;
        ex_jump_addr_i   = 32'h100;
        tick();
        check("int_flag", 32'(jump_flag_o), 32'd1);
        check("int_addr", jump_addr_o, 32'h80);
        check("int_ack", 32'(int_ack_o), 32'd1);
        clint_int_req_i = 1'b0;
        ex_jump_req_i   = 1'b0;
        tick();
        check("int_ack_pulse", 32'(int_ack_o), 32'd0);
        check("int_flag_pulse", 32'(jump_flag_o), 32'd0);
        check("int_no_ex_addr", jump_addr_o, 32'h80);

        // 4a: single-cycle JTAG reset request -> 4-cycle train, EX ignored
        jtag_reset_req_i = 1'b1;
        tick();
        jtag_reset_req_i = 1'b0;
        ex_jump_req_i    = 1'b1;
        ex_jump_addr_i   = 32'h300;
        check("jrst_flag_c1", 32'(jtag_reset_flag_o), 32'd1);
        check("jrst_hold_c1", 32'(hold_flag_o), 32'd3);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("jrst_flag_c%0d", i), 32'(jtag_reset_flag_o), 32'd1);
            check($sformatf("jrst_hold_c%0d", i), 32'(hold_flag_o), 32'd3);
            check($sformatf("jrst_nojump_c%0d", i), 32'(jump_flag_o), 32'd0);
        end
        tick();
        check("jrst_end_flag", 32'(jtag_reset_flag_o), 32'd0);
        check("jrst_end_nojump", 32'(jump_flag_o), 32'd0);
        ex_jump_req_i = 1'b0;
        #1;
        check("jrst_end_hold", 32'(hold_flag_o), 32'd0);
        check("jrst_addr_kept", jump_addr_o, 32'h80);

        // 4b: request held during JRST does not extend the train
        jtag_reset_req_i = 1'b1;
        tick();
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("retrig_flag_c%0d", i), 32'(jtag_reset_flag_o), 32'd1);
        end
        jtag_reset_req_i = 1'b0;
        tick();
        check("retrig_end_flag", 32'(jtag_reset_flag_o), 32'd0);

        // 4c: rst in second JRST cycle clears flag next cycle
        jtag_reset_req_i = 1'b1;
        tick();
        jtag_reset_req_i = 1'b0;
        tick();
        check("jrst_mid_flag", 32'(jtag_reset_flag_o), 32'd1);
        rst = 1'b1;
        tick();
        check("jrst_rst_flag", 32'(jtag_reset_flag_o), 32'd0);
        check("jrst_rst_hold", 32'(hold_flag_o), 32'd0);
        check("jrst_rst_addr", jump_addr_o, 32'h0);
        rst = 1'b0;

        // 5: halt for 10 cycles with interrupt pending, then interrupt taken
        jtag_halt_req_i = 1'b1;
        tick();
        check("halt_halted", 32'(halted_o), 32'd1);
        check("halt_hold", 32'(hold_flag_o), 32'd3);
        clint_int_req_i  = 1'b1;
        clint_int_addr_i = 32'h90;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("halt_stay", 32'(halted_o), 32'd1);
            check("halt_no_jump", 32'(jump_flag_o), 32'd0);
            check("halt_no_ack", 32'(int_ack_o), 32'd0);
        end
        jtag_halt_req_i = 1'b0;
        tick();
        check("unhalt_halted", 32'(halted_o), 32'd0);
        check("unhalt_no_jump", 32'(jump_flag_o), 32'd0);
        tick();
        check("pend_int_flag", 32'(jump_flag_o), 32'd1);
        check("pend_int_addr", jump_addr_o, 32'h90);
        check("pend_int_ack", 32'(int_ack_o), 32'd1);
        clint_int_req_i = 1'b0;
        tick();
        check("pend_int_ack_end", 32'(int_ack_o), 32'd0);

        // 6: stall combinations
        rib_hold_req_i = 1'b1;
        #1;
        check("hold_rib", 32'(hold_flag_o), 32'd1);
        ex_hold_req_i = 1'b1;
        #1;
        check("hold_rib_ex", 32'(hold_flag_o), 32'd3);
        rib_hold_req_i = 1'b0;
        #1;
        check("hold_ex", 32'(hold_flag_o), 32'd3);
        ex_hold_req_i = 1'b0;
        #1;
        check("hold_none", 32'(hold_flag_o), 32'd0);

        // Three jumps after a fresh reset (feeds the stats counters)
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            ex_jump_req_i  = 1'b1;
            ex_jump_addr_i = 32'h400 + 32'(k * 4);
            tick();
            check($sformatf("stat_jump%0d", k), 32'(jump_flag_o), 32'd1);
            ex_jump_req_i = 1'b0;
            tick();
        end
        check("stat_last_addr", jump_addr_o, 32'h408);
`ifdef PC_CTRL_STATS_EN
        check("stat_jump_cnt", jump_cnt_o, 32'd3);
        check("stat_hold_cnt", hold_cnt_o, 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
